// File: rtl/pll_seq_pkg.sv
// Shared types, defaults and sizing helper for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    PLL_RST   = 3'd2,
    CPU_HOLD  = 3'd3,
    RUN       = 3'd4
  } seq_state_e;

  localparam int unsigned DEF_SYNC_STAGES  = 2;
  localparam int unsigned DEF_STABLE_CYC   = 1024;
  localparam int unsigned DEF_CPU_HOLD_CYC = 256;
  localparam int unsigned DEF_LOCK_TIMEOUT = 65536;
  localparam int unsigned DEF_PLL_RST_CYC  = 16;
  localparam int unsigned DEF_CE_DIV       = 6;

  // Width able to hold 0..max-1 of the four terminal counts.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// Generic multi-stage flop synchroniser for a single asynchronous bit.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Orders PLL lock qualification, system/CPU reset release and the CPU clock enable;
// retries the PLL with a reset pulse when lock never arrives.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYC   = DEF_STABLE_CYC,
  parameter int unsigned CPU_HOLD_CYC = DEF_CPU_HOLD_CYC,
  parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int unsigned PLL_RST_CYC  = DEF_PLL_RST_CYC,
  parameter int unsigned CE_DIV       = DEF_CE_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_reset,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       cpu_rst_n,
  output logic       cpu_ce,
  output logic [2:0] state
);

  localparam int unsigned CW = cnt_width(LOCK_TIMEOUT, STABLE_CYC, CPU_HOLD_CYC, PLL_RST_CYC);
  localparam int unsigned DW = $clog2(CE_DIV);

  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] PR_LAST  = CW'(PLL_RST_CYC - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(CPU_HOLD_CYC - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CE_DIV - 1);

  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic          locked_s;
  logic          active_q, active_d;
  logic          pll_rst_d, sys_rst_n_d, cpu_rst_n_d, cpu_ce_d;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      div_q     <= '0;
      pll_rst   <= 1'b0;
      sys_rst_n <= 1'b0;
      cpu_rst_n <= 1'b0;
      cpu_ce    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      pll_rst   <= pll_rst_d;
      sys_rst_n <= sys_rst_n_d;
      cpu_rst_n <= cpu_rst_n_d;
      cpu_ce    <= cpu_ce_d;
    end
  end

  // Next state and counter; loss of lock is checked before any terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = PLL_RST;
          cnt_d   = '0;
        end
      end
      PLL_RST: begin
        if (cnt_q == PR_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == ST_LAST) begin
          state_d = CPU_HOLD;
          cnt_d   = '0;
        end
      end
      CPU_HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CH_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!locked_s)       state_d = WAIT_LOCK;
        else if (soft_reset) state_d = CPU_HOLD;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state; divider keeps phase across soft resets.
  always_comb begin
    active_q    = (state_q == CPU_HOLD) || (state_q == RUN);
    active_d    = (state_d == CPU_HOLD) || (state_d == RUN);
    div_d       = '0;
    cpu_ce_d    = 1'b0;
    if (active_q && active_d) begin
      cpu_ce_d = (div_q == DIV_LAST);
      div_d    = cpu_ce_d ? '0 : div_q + DW'(1);
    end
    pll_rst_d   = (state_d == PLL_RST);
    sys_rst_n_d = active_d;
    cpu_rst_n_d = (state_d == RUN);
  end

  assign state = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed and randomized checks of pll_reset_sequencer against a timestamp-based model.
module tb_pll_reset_sequencer;

  localparam int SYNC = 2;
  localparam int ST   = 16;
  localparam int CH   = 8;
  localparam int TO   = 100;
  localparam int PR   = 4;
  localparam int CE   = 3;

  localparam int P_WAIT = 0, P_STABLE = 1, P_PLLR = 2, P_HOLD = 3, P_RUN = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_reset = 1'b0;
  logic       pll_rst, sys_rst_n, cpu_rst_n, cpu_ce;
  logic [2:0] state;

  pll_reset_sequencer #(
    .SYNC_STAGES(SYNC), .STABLE_CYC(ST), .CPU_HOLD_CYC(CH),
    .LOCK_TIMEOUT(TO), .PLL_RST_CYC(PR), .CE_DIV(CE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .soft_reset(soft_reset),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .cpu_rst_n(cpu_rst_n),
    .cpu_ce(cpu_ce), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: phase, edge of phase entry, edge of entering the CE region, lock delay line.
  int            ph, ent, e0, n, last_ce, ce_gap;
  logic [SYNC-1:0] syn;
  logic [6:0]    exp_v;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int obs_vec();
    return int'({state, pll_rst, sys_rst_n, cpu_rst_n, cpu_ce});
  endfunction

  task automatic m_reset();
    ph = P_WAIT; ent = 0; e0 = 0; n = 0; syn = '0; last_ce = -1000; ce_gap = 0;
    exp_v = '0;
  endtask

  task automatic go(input int p);
    ph  = p;
    ent = n;
  endtask

  task automatic model_edge();
    logic ls;
    int   age;
    bit   was_act, is_act, ce_e;
    n++;
    ls  = syn[SYNC-1];
    syn = {syn[SYNC-2:0], pll_locked};
    age = n - ent;
    was_act = (ph == P_HOLD) || (ph == P_RUN);
    case (ph)
      P_WAIT:   if (ls) go(P_STABLE); else if (age == TO) go(P_PLLR);
      P_PLLR:   if (age == PR) go(P_WAIT);
      P_STABLE: if (!ls) go(P_WAIT); else if (age == ST) begin go(P_HOLD); e0 = n; end
      P_HOLD:   if (!ls) go(P_WAIT); else if (age == CH) go(P_RUN);
      default:  if (!ls) go(P_WAIT); else if (soft_reset) go(P_HOLD);
    endcase
    is_act = (ph == P_HOLD) || (ph == P_RUN);
    ce_e   = was_act && is_act && ((n - e0) % CE == 0);
    exp_v  = {3'(ph), (ph == P_PLLR), is_act, (ph == P_RUN), ce_e};
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("cycle", obs_vec(), int'(exp_v));
    if (cpu_ce === 1'b1) begin
      ce_gap  = n - last_ce;
      last_ce = n;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  initial begin
    int k, c, first_ce, rise1, lowc, hold_left;
    bit lvl;
    m_reset();

    // Reset values while rst_n is held low; lock arrives before release.
    #23;
    chk("reset_vals", obs_vec(), 0);
    pll_locked = 1'b1;
    #20;
    release_reset();
    k = 0;
    while (sys_rst_n !== 1'b1 && k < 100) begin step(); k++; end
    chk("sys_rise_lat", k, SYNC + ST + 1);
    c = 0; first_ce = -1;
    while (cpu_rst_n !== 1'b1 && c < 100) begin
      step(); c++;
      if (cpu_ce === 1'b1 && first_ce < 0) first_ce = c;
    end
    chk("cpu_rise_lat", c, CH);
    chk("first_ce", first_ce, CE);

    // Soft reset in RUN: CPU-only re-reset, continuous CE phase.
    repeat (4) step();
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    lowc = 0;
    while (cpu_rst_n !== 1'b1 && lowc < 50) begin
      lowc++;
      chk("soft_sys_hi", int'(sys_rst_n), 1);
      if (cpu_ce === 1'b1) chk("ce_period", ce_gap, CE);
      step();
    end
    chk("soft_low_cyc", lowc, CH);
    repeat (6) begin
      step();
      if (cpu_ce === 1'b1) chk("ce_period", ce_gap, CE);
    end

    // Loss of lock in RUN.
    pll_locked = 1'b0;
    k = 0;
    while (sys_rst_n !== 1'b0 && k < 20) begin step(); k++; end
    chk("loss_lat", k, SYNC + 1);
    chk("loss_state", int'(state), P_WAIT);
    chk("loss_cpu_ce", int'({cpu_rst_n, cpu_ce}), 0);

    // No lock at all: watchdog pulses pll_rst repeatedly.
    rst_n = 1'b0;
    #12;
    release_reset();
    k = 0;
    while (pll_rst !== 1'b1 && k < 300) begin step(); k++; end
    chk("pll_rst_first", k, TO);
    rise1 = n; c = 0;
    while (pll_rst === 1'b1 && c < 20) begin step(); c++; end
    chk("pll_rst_width", c, PR);
    while (pll_rst !== 1'b1 && n < rise1 + 300) step();
    chk("pll_rst_period", n - rise1, TO + PR);
    chk("nolock_sys", int'(sys_rst_n), 0);

    // Lock glitch at STABLE cnt=10 restarts the stability count.
    while (pll_rst === 1'b1) step();
    pll_locked = 1'b1;
    k = 0;
    while (state !== 3'(P_STABLE) && k < 20) begin step(); k++; end
    repeat (10) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    k = 0;
    while (sys_rst_n !== 1'b1 && k < 100) begin step(); k++; end
    chk("glitch_relock_lat", k, SYNC + ST + 1);

    // Asynchronous reset mid CPU_HOLD, then a clean restart.
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("async_rst", obs_vec(), 0);
    #14;
    release_reset();
    k = 0;
    while (sys_rst_n !== 1'b1 && k < 100) begin step(); k++; end
    chk("restart_lat", k, SYNC + ST + 1);

    // Randomized lock behaviour and soft resets against the model.
    hold_left = 0;
    repeat (3000) begin
      if (hold_left == 0) begin
        lvl        = ($urandom_range(0, 3) != 0);
        hold_left  = lvl ? int'($urandom_range(5, 120)) : int'($urandom_range(1, 250));
        pll_locked = lvl;
      end
      hold_left--;
      soft_reset = ($urandom_range(0, 31) == 0);
      step();
    end
    soft_reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the system PLL wrapper.
- Runs on the PLL's fast output clock and consumes the PLL `locked` flag.
- Produces an ordered system reset, a delayed CPU reset and the Z80 CPU clock-enable pulse.
- Watchdogs the PLL: if lock never arrives, it pulses the PLL's reset input and retries.

Parameters:
- SYNC_STAGES, 2: flip-flop stages synchronising pll_locked into clk; minimum 2.
- STABLE_CYC, 1024: cycles of continuous lock required before sys_rst_n releases.
- CPU_HOLD_CYC, 256: cycles cpu_rst_n stays low after sys_rst_n releases, with cpu_ce running.
- LOCK_TIMEOUT, 65536: cycles spent in WAIT_LOCK without lock before a PLL reset is issued.
- PLL_RST_CYC, 16: width of the pll_rst pulse, in cycles.
- CE_DIV, 6: cpu_ce period in clk cycles; minimum 2.

Ports:
- clk  in  1  PLL outclk_0; sole clock.
- rst_n  in  1  asynchronous, active-low master reset (board/framework reset).
- pll_locked  in  1  PLL locked flag; asynchronous to clk.
- soft_reset  in  1  synchronous request to re-reset the CPU only; sampled every cycle.
- pll_rst  out  1  active-high reset to the PLL rst input.
- sys_rst_n  out  1  active-low reset for video, memory and peripherals.
- cpu_rst_n  out  1  active-low Z80 reset.
- cpu_ce  out  1  one-cycle CPU clock-enable pulse.
- state  out  3  current FSM state, for debug/OSD.

Behaviour:
- Reset (rst_n=0, asynchronous) forces:
  - state=WAIT_LOCK(0), all counters 0, synchroniser flops 0.
  - pll_rst=0, sys_rst_n=0, cpu_rst_n=0, cpu_ce=0.
- locked_s is pll_locked after SYNC_STAGES flops. Only locked_s is used internally.
- State encodings: WAIT_LOCK=0, STABLE=1, PLL_RST=2, CPU_HOLD=3, RUN=4.
- All outputs are registered and decoded from the next state, so they change on the same edge as state.
- WAIT_LOCK:
  - sys_rst_n=0, cpu_rst_n=0, cpu_ce=0; cnt increments every cycle.
  - locked_s=1 -> STABLE, cnt=0.
  - Otherwise, cnt==LOCK_TIMEOUT-1 -> PLL_RST, cnt=0.
- PLL_RST:
  - pll_rst=1 for exactly PLL_RST_CYC cycles, then WAIT_LOCK with cnt=0.
  - locked_s is ignored in this state.
- STABLE:
  - cnt increments while locked_s=1. locked_s=0 -> WAIT_LOCK, cnt=0.
  - cnt==STABLE_CYC-1 -> CPU_HOLD, cnt=0; sys_rst_n rises on this edge.
- CPU_HOLD:
  - sys_rst_n=1, cpu_rst_n=0, cpu_ce active.
  - cnt==CPU_HOLD_CYC-1 -> RUN; cpu_rst_n rises on this edge.
- RUN:
  - All resets released; cpu_ce active.
  - soft_reset=1 -> CPU_HOLD, cnt=0; cpu_rst_n falls, sys_rst_n stays 1.
- Loss of lock: locked_s=0 in STABLE, CPU_HOLD or RUN -> WAIT_LOCK on the next edge.
  - sys_rst_n and cpu_rst_n both fall on that edge; cpu_ce drops.
  - Loss of lock has priority over soft_reset and over counter terminal counts.
- soft_reset in any state other than RUN is ignored.
- cpu_ce divider:
  - div counts 0..CE_DIV-1 only in CPU_HOLD and RUN; it is cleared to 0 in all other states.
  - cpu_ce=1 for exactly one cycle when div==CE_DIV-1, then div wraps to 0.
  - First pulse comes CE_DIV cycles after entering CPU_HOLD from STABLE.
  - The divider is not cleared on a RUN->CPU_HOLD soft reset, so the cpu_ce phase is continuous.
- Latency: first clk edge sampling pll_locked=1 is edge 1. sys_rst_n rises on edge SYNC_STAGES+STABLE_CYC+1, and cpu_rst_n rises CPU_HOLD_CYC edges later.
- Counter width: clog2 of the largest of LOCK_TIMEOUT, STABLE_CYC, CPU_HOLD_CYC, PLL_RST_CYC. Terminal compares are exact equality; no wrap occurs in any state.

Decomposition:
- Package pll_seq_pkg holds:
  - state typedef with the five encodings;
  - a clog2-based counter-width function;
  - default parameter constants.
- One sub-module, sync_bit: a generic SYNC_STAGES flop synchroniser with async active-low reset. It is used for pll_locked.

Test Plan (STABLE_CYC=16, CPU_HOLD_CYC=8, LOCK_TIMEOUT=100, PLL_RST_CYC=4, CE_DIV=3, SYNC_STAGES=2):
- Assert rst_n low, then raise pll_locked before rst_n releases -> sys_rst_n rises 19 edges after release, cpu_rst_n 8 edges later; cpu_ce pulses every 3rd cycle starting 3 cycles after sys_rst_n rises.
- pll_locked held 0 -> pll_rst high for 4 cycles after 100 cycles in WAIT_LOCK, then repeats every 104 cycles; sys_rst_n stays 0.
- pll_locked drops for 1 cycle at STABLE cnt=10 -> return to WAIT_LOCK; full 16-cycle count restarts after relock; sys_rst_n never glitches high.
- In RUN, drive pll_locked low -> sys_rst_n and cpu_rst_n low 3 edges later (2 sync + 1); cpu_ce 0; state=0.
- In RUN, pulse soft_reset 1 cycle -> cpu_rst_n low for exactly 8 cycles; sys_rst_n stays 1; cpu_ce period stays 3 with no phase break.
- Assert rst_n mid-CPU_HOLD -> all outputs at reset values immediately (asynchronously); sequence restarts from WAIT_LOCK.
